// File: rtl/free_list_pkg.sv
// Shared definitions for the rename/commit front end.
//   FL_WIDTH_REG : physical register tag width
//   FL_NUM_ARCH  : architectural registers, mapped at reset
//   NUM_LANES    : dispatch/commit lanes per cycle
//   lane_tag()   : extracts lane k from a packed 4-lane tag vector
package free_list_pkg;

  localparam int FL_WIDTH_REG = 7;
  localparam int FL_NUM_ARCH  = 32;
  localparam int NUM_LANES    = 4;

  function automatic logic [FL_WIDTH_REG-1:0] lane_tag(
    input logic [NUM_LANES*FL_WIDTH_REG-1:0] vec,
    input int unsigned                       k
  );
    return vec[k*FL_WIDTH_REG +: FL_WIDTH_REG];
  endfunction

endpackage

// File: rtl/free_list_compact.sv
// Packs the enabled lanes of a 4-lane tag vector toward lane 0, keeping their
// ascending lane order, and reports how many lanes were enabled.
//   i_lanes : 4 packed tags, lane k at [k*W +: W]
//   i_en    : per-lane valid mask
//   o_lanes : compacted tags; lanes at and above o_cnt read as zero
//   o_cnt   : popcount of i_en (0..4)
module free_list_compact
  import free_list_pkg::*;
#(
  parameter int W = FL_WIDTH_REG
) (
  input  logic [NUM_LANES*W-1:0] i_lanes,
  input  logic [NUM_LANES-1:0]   i_en,
  output logic [NUM_LANES*W-1:0] o_lanes,
  output logic [2:0]             o_cnt
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    o_lanes = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (i_en[k]) begin
        o_lanes[idx*W +: W] = i_lanes[k*W +: W];
        idx = idx + 1;
      end
    end
    o_cnt = 3'(idx);
  end

endmodule

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of tags. Rename pulls 4 tags at
// a time from the head; the ROB returns up to 4 tags per cycle at the tail,
// compacted so that only enabled lanes occupy slots.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   o_prd4x       : next 4 free tags, lane 0 oldest
//   o_valid       : at least 4 tags available
//   o_count       : number of tags held
//   o_ovf         : sticky overflow (a free would have exceeded DEPTH)
//   i_alloc_en    : rename takes all 4 lanes this cycle
//   i_free_prd4x  : tags released at commit, same packing as o_prd4x
//   i_free_en4    : per-lane release valid
module free_list
  import free_list_pkg::*;
#(
  parameter int WIDTH_REG = FL_WIDTH_REG,
  parameter int NUM_ARCH  = FL_NUM_ARCH
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  output logic [NUM_LANES*WIDTH_REG-1:0] o_prd4x,
  output logic                           o_valid,
  output logic [WIDTH_REG:0]             o_count,
  output logic                           o_ovf,
  input  logic                           i_alloc_en,
  input  logic [NUM_LANES*WIDTH_REG-1:0] i_free_prd4x,
  input  logic [NUM_LANES-1:0]           i_free_en4
);

  localparam int DEPTH = 2**WIDTH_REG;

  typedef logic [WIDTH_REG-1:0] tag_t;
  typedef logic [WIDTH_REG:0]   ptr_t;
  typedef logic [WIDTH_REG+1:0] sum_t;

  tag_t mem_q [DEPTH];
  tag_t mem_d [DEPTH];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t count_q, count_d;
  logic ovf_q, ovf_d;

  logic [NUM_LANES*WIDTH_REG-1:0] cmp_lanes;
  logic [2:0]                     cmp_cnt;

  logic alloc_take;
  logic free_drop;
  ptr_t count_after_alloc;
  sum_t count_sum;

  free_list_compact #(.W(WIDTH_REG)) u_compact (
    .i_lanes (i_free_prd4x),
    .i_en    (i_free_en4),
    .o_lanes (cmp_lanes),
    .o_cnt   (cmp_cnt)
  );

  always_comb begin
    alloc_take        = i_alloc_en && (count_q >= ptr_t'(NUM_LANES));
    count_after_alloc = alloc_take ? (count_q - ptr_t'(NUM_LANES)) : count_q;
    // One extra bit so a sum just over DEPTH cannot alias back into range.
    count_sum = {1'b0, count_after_alloc} + sum_t'(cmp_cnt);
    // An overflowing free is dropped as a whole; the alloc still goes ahead.
    free_drop = count_sum > sum_t'(DEPTH);

    head_d  = alloc_take ? (head_q + ptr_t'(NUM_LANES)) : head_q;
    tail_d  = tail_q;
    count_d = count_after_alloc;
    ovf_d   = ovf_q | free_drop;
    mem_d   = mem_q;

    if (!free_drop) begin
      tail_d  = tail_q + ptr_t'(cmp_cnt);
      count_d = count_sum[WIDTH_REG:0];
      for (int k = 0; k < NUM_LANES; k++) begin
        if (k < int'(cmp_cnt)) begin
          mem_d[tail_q[WIDTH_REG-1:0] + tag_t'(k)] = cmp_lanes[k*WIDTH_REG +: WIDTH_REG];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < DEPTH - NUM_ARCH) ? tag_t'(NUM_ARCH + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= ptr_t'(DEPTH - NUM_ARCH);
      count_q <= ptr_t'(DEPTH - NUM_ARCH);
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Read side sees only registered state, so same-cycle frees never leak out.
  always_comb begin
    o_prd4x = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      o_prd4x[k*WIDTH_REG +: WIDTH_REG] = mem_q[head_q[WIDTH_REG-1:0] + tag_t'(k)];
    end
  end

  assign o_valid = count_q >= ptr_t'(NUM_LANES);
  assign o_count = count_q;
  assign o_ovf   = ovf_q;

endmodule
